victim_write_buffer: RTL and testbench

//  Parametrised multi-entry eviction write buffer between the L2 cache and the cacheline adaptor.

---
 rtl/vwb_pkg.sv | 19 +
 rtl/vwb_match.sv | 38 +++
 rtl/victim_write_buffer.sv | 178 +++++++++++++++++
 tb/tb_victim_write_buffer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vwb_pkg.sv
// Shared types and helpers for the victim write buffer.
package vwb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP   = 2'd1,
        RD_MEM = 2'd2,
        DRAIN  = 2'd3
    } vwb_state_e;

    localparam int unsigned MaxAddrW = 64;

    // Strip the byte-offset bits so addresses compare at cacheline granularity.
    function automatic logic [MaxAddrW-1:0] line_addr(input logic [MaxAddrW-1:0] addr,
                                                      input int unsigned        off_w);
        return addr >> off_w;
    endfunction

endpackage

// File: rtl/vwb_match.sv
// DEPTH-way line-address compare. The in-flight head can be excluded from matching, and a
// non-head match is preferred over a head match when both exist.
module vwb_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LA_W  = 27,
    localparam int unsigned IdxW = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid_i,
    input  logic [LA_W-1:0]  laddr_i [DEPTH],
    input  logic [LA_W-1:0]  query_i,
    input  logic [IdxW-1:0]  head_i,
    input  logic             excl_i,
    output logic             hit_o,
    output logic [DEPTH-1:0] match_o,
    output logic [IdxW-1:0]  idx_o
);

    logic found;

    // Per-entry compare, then pick the first non-head match, falling back to the head.
    always_comb begin
        match_o = '0;
        idx_o   = head_i;
        found   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            match_o[i] = valid_i[i] && (laddr_i[i] == query_i) &&
                         !(excl_i && (IdxW'(i) == head_i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (match_o[i] && (IdxW'(i) != head_i) && !found) begin
                idx_o = IdxW'(i);
                found = 1'b1;
            end
        end
        hit_o = |match_o;
    end

endmodule

// File: rtl/victim_write_buffer.sv
// Victim write buffer between L2 and the cacheline adaptor: buffers dirty writebacks in a
// circular FIFO, coalesces repeated writebacks, forwards read hits and drains in FIFO order.
// Optional feature: define VWB_EAGER_DRAIN_EN to drain whenever L2 is idle and the buffer is
// non-empty; otherwise entries are written to memory only to free a slot.
module victim_write_buffer
    import vwb_pkg::*;
#(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o,
    output logic              resp_o,
    output logic              read_o,
    output logic              write_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [LINE_W-1:0] wdata_o,
    input  logic [LINE_W-1:0] rdata_i,
    input  logic              resp_i
);

    localparam int unsigned OffW = $clog2(LINE_W / 8);
    localparam int unsigned LaW  = ADDR_W - OffW;
    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = IdxW + 1;

    vwb_state_e        state_q, state_d;
    logic [DEPTH-1:0]  valid_q;
    logic [LaW-1:0]    laddr_q [DEPTH];
    logic [LINE_W-1:0] data_q  [DEPTH];
    logic [IdxW-1:0]   head_q, tail_q;
    logic [CntW-1:0]   count_q;
    logic [LINE_W-1:0] rdata_q;

    logic [LaW-1:0]    q_laddr;
    logic              hit;
    logic [DEPTH-1:0]  match_vec;
    logic [IdxW-1:0]   hit_idx;
    logic              full, drain_cond;
    logic              do_alloc, do_coal, do_retire, do_rhit;

    assign q_laddr = LaW'(line_addr(MaxAddrW'(addr_i), OffW));
    assign full    = (count_q == CntW'(DEPTH));

`ifdef VWB_EAGER_DRAIN_EN
    assign drain_cond = (count_q != '0);
`else
    assign drain_cond = full;
`endif

    vwb_match #(
        .DEPTH (DEPTH),
        .LA_W  (LaW)
    ) u_match (
        .valid_i (valid_q),
        .laddr_i (laddr_q),
        .query_i (q_laddr),
        .head_i  (head_q),
        .excl_i  (state_q == DRAIN),
        .hit_o   (hit),
        .match_o (match_vec),
        .idx_o   (hit_idx)
    );

    // Next-state decode and memory/L2 handshake outputs.
    always_comb begin
        state_d   = state_q;
        resp_o    = 1'b0;
        rdata_o   = '0;
        read_o    = 1'b0;
        write_o   = 1'b0;
        addr_o    = '0;
        wdata_o   = '0;
        do_alloc  = 1'b0;
        do_coal   = 1'b0;
        do_retire = 1'b0;
        do_rhit   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (read_i) begin
                    if (hit) begin
                        do_rhit = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = RD_MEM;
                    end
                end else if (write_i) begin
                    if (hit) begin
                        do_coal = 1'b1;
                        state_d = RESP;
                    end else if (!full) begin
                        do_alloc = 1'b1;
                        state_d  = RESP;
                    end else begin
                        // Free the head slot first; the held write is retried from IDLE.
                        state_d = DRAIN;
                    end
                end else if (drain_cond) begin
                    state_d = DRAIN;
                end
            end
            RESP: begin
                resp_o  = 1'b1;
                rdata_o = rdata_q;
                state_d = IDLE;
            end
            RD_MEM: begin
                read_o = 1'b1;
                addr_o = {q_laddr, {OffW{1'b0}}};
                if (resp_i) begin
                    resp_o  = 1'b1;
                    rdata_o = rdata_i;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                write_o = 1'b1;
                addr_o  = {laddr_q[head_q], {OffW{1'b0}}};
                wdata_o = data_q[head_q];
                if (resp_i) begin
                    do_retire = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, entry tags and FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                laddr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (do_alloc) begin
                valid_q[tail_q] <= 1'b1;
                laddr_q[tail_q] <= q_laddr;
                tail_q          <= tail_q + IdxW'(1);
                count_q         <= count_q + CntW'(1);
            end
            if (do_retire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + IdxW'(1);
                count_q         <= count_q - CntW'(1);
            end
            if (do_rhit) begin
                rdata_q <= data_q[hit_idx];
            end
        end
    end

    // Line data storage; contents are qualified by valid_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            data_q[tail_q] <= wdata_i;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (do_coal && match_vec[i]) begin
                data_q[i] <= wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_victim_write_buffer.sv
// Directed self-checking bench for victim_write_buffer (default lazy-drain build; the eager
// drain section switches on VWB_EAGER_DRAIN_EN). The bench also acts as the memory side.
module tb_victim_write_buffer;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;
    typedef logic [LINE_W-1:0] line_t;
    typedef logic [ADDR_W-1:0] addr_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  read_i = 1'b0, write_i = 1'b0, resp_i = 1'b0;
    addr_t addr_i = '0;
    line_t wdata_i = '0, rdata_i = '0;
    line_t rdata_o, wdata_o;
    logic  resp_o, read_o, write_o;
    addr_t addr_o;

    int    checks = 0;
    int    errors = 0;
    int    mem_lat = 2;
    int    mem_cyc = 0;
    int    rd_cycles = 0;
    addr_t rd_addr = '0;
    addr_t wr_addr_q[$];
    line_t wr_data_q[$];
    line_t mem_line = '0;

    victim_write_buffer #(
        .LINE_W (LINE_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .read_i  (read_i),
        .write_i (write_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .resp_o  (resp_o),
        .read_o  (read_o),
        .write_o (write_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .rdata_i (rdata_i),
        .resp_i  (resp_i)
    );

    always #5 clk = ~clk;

    function automatic line_t pat(input int unsigned k);
        return {8{32'hA500_0000 + k[31:0]}};
    endfunction

    task automatic check_eq(input string tag, input line_t got, input line_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One clock cycle: act as memory (respond after mem_lat request cycles), sample L2 side.
    task automatic step(output bit r, output line_t d);
        if (read_o || write_o) begin
            mem_cyc++;
            if (read_o) begin
                rd_cycles++;
                rd_addr = addr_o;
            end
            if (mem_cyc >= mem_lat) begin
                resp_i  = 1'b1;
                rdata_i = mem_line;
                if (write_o) begin
                    wr_addr_q.push_back(addr_o);
                    wr_data_q.push_back(wdata_o);
                end
            end
        end
        #1;
        r = resp_o;
        d = rdata_o;
        @(posedge clk);
        #1;
        if (resp_i) mem_cyc = 0;
        resp_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bit    r;
        line_t d;
        repeat (n) step(r, d);
    endtask

    // Full L2 transaction; cyc is the number of cycles from request to the resp_o cycle.
    task automatic l2_txn(input bit wr, input addr_t a, input line_t d, output int cyc,
                          output line_t rd);
        bit    r;
        line_t q;
        int    k;
        read_i  = !wr;
        write_i = wr;
        addr_i  = a;
        wdata_i = d;
        r = 1'b0;
        q = '0;
        for (k = 0; k < 200; k++) begin
            step(r, q);
            if (r) break;
        end
        cyc = k;
        rd  = q;
        if (!r) check_eq("txn_timeout", line_t'(0), line_t'(1));
        read_i  = 1'b0;
        write_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        read_i = 1'b0;
        write_i = 1'b0;
        resp_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_cyc = 0;
        rd_cycles = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        int    cyc;
        line_t rd;

        mem_line = {8{32'h5A5A_0F0F}};
        do_reset();
        check_eq("rst_ctrl", line_t'({resp_o, read_o, write_o}), line_t'(0));
        check_eq("rst_addr", line_t'(addr_o), line_t'(0));
        check_eq("rst_rdata", rdata_o, line_t'(0));
        check_eq("rst_wdata", wdata_o, line_t'(0));

        // Write then read-hit forwarding.
        l2_txn(1'b1, 32'h100, pat(0), cyc, rd);
        check_eq("t1_wr_lat", line_t'(cyc), line_t'(1));
        l2_txn(1'b0, 32'h100, '0, cyc, rd);
        check_eq("t1_rd_lat", line_t'(cyc), line_t'(1));
        check_eq("t1_rd_data", rd, pat(0));
        check_eq("t1_no_read_o", line_t'(rd_cycles), line_t'(0));

        // Coalesce, then fill; only a full buffer forces the (coalesced) head out.
        l2_txn(1'b1, 32'h100, pat(1), cyc, rd);
        l2_txn(1'b0, 32'h11C, '0, cyc, rd);
        check_eq("t2_rd_coal", rd, pat(1));
        l2_txn(1'b1, 32'h120, pat(2), cyc, rd);
        l2_txn(1'b1, 32'h140, pat(3), cyc, rd);
        l2_txn(1'b1, 32'h160, pat(4), cyc, rd);
        check_eq("t2_no_drain", line_t'(wr_addr_q.size()), line_t'(0));
        mem_lat = 3;
        l2_txn(1'b1, 32'h180, pat(5), cyc, rd);
        check_eq("t2_full_lat", line_t'(cyc), line_t'(5));
        check_eq("t2_drain_n", line_t'(wr_addr_q.size()), line_t'(1));
        if (wr_addr_q.size() > 0) begin
            check_eq("t2_drain_addr", line_t'(wr_addr_q[0]), line_t'(32'h100));
            check_eq("t2_drain_data", wr_data_q[0], pat(1));
        end
        l2_txn(1'b0, 32'h180, '0, cyc, rd);
        check_eq("t2_rd_new", rd, pat(5));
        check_eq("t2_rd_new_hit", line_t'(rd_cycles), line_t'(0));
        l2_txn(1'b0, 32'h100, '0, cyc, rd);
        check_eq("t2_rd_drained", rd, mem_line);
        check_eq("t2_rd_drained_mem", line_t'(rd_cycles), line_t'(3));

        // Lazy mode, DEPTH=4: fifth distinct write evicts 0x000 first.
        do_reset();
        mem_lat = 2;
        for (int i = 0; i < 4; i++) l2_txn(1'b1, addr_t'(32 * i), pat(10 + i), cyc, rd);
        l2_txn(1'b1, 32'h080, pat(14), cyc, rd);
        check_eq("t3_first_wr", line_t'(wr_addr_q.size() > 0 ? wr_addr_q[0] : 32'hFFFF_FFFF),
                 line_t'(0));
        check_eq("t3_wr_lat", line_t'(cyc), line_t'(4));
        for (int i = 1; i < 5; i++) begin
            l2_txn(1'b0, addr_t'(32 * i), '0, cyc, rd);
            check_eq("t3_rd_hit", rd, pat(10 + i));
        end
        check_eq("t3_no_read_o", line_t'(rd_cycles), line_t'(0));

        // Read miss, memory answers after 5 cycles; also an unaligned miss address.
        mem_lat = 5;
        mem_line = {8{32'hC0FF_EE00}};
        l2_txn(1'b0, 32'h200, '0, cyc, rd);
        check_eq("t4_lat", line_t'(cyc), line_t'(5));
        check_eq("t4_read_cycles", line_t'(rd_cycles), line_t'(5));
        check_eq("t4_data", rd, mem_line);
        check_eq("t4_addr", line_t'(rd_addr), line_t'(32'h200));
        mem_lat = 1;
        l2_txn(1'b0, 32'h33F, '0, cyc, rd);
        check_eq("t4_unaligned_addr", line_t'(rd_addr), line_t'(32'h320));
        check_eq("t4_lat1", line_t'(cyc), line_t'(1));

        // Drain and L2-idle behaviour with two buffered lines.
        do_reset();
        mem_lat = 2;
        l2_txn(1'b1, 32'h400, pat(20), cyc, rd);
        l2_txn(1'b1, 32'h420, pat(21), cyc, rd);
        idle(12);
`ifdef VWB_EAGER_DRAIN_EN
        check_eq("t5_eager_n", line_t'(wr_addr_q.size()), line_t'(2));
        if (wr_addr_q.size() == 2) begin
            check_eq("t5_eager_0", line_t'(wr_addr_q[0]), line_t'(32'h400));
            check_eq("t5_eager_1", line_t'(wr_addr_q[1]), line_t'(32'h420));
        end
`else
        check_eq("t5_lazy_n", line_t'(wr_addr_q.size()), line_t'(0));
        l2_txn(1'b0, 32'h420, '0, cyc, rd);
        check_eq("t5_lazy_hit", rd, pat(21));
`endif

        // Reset in the middle of a drain.
        do_reset();
        mem_lat = 1000;
        for (int i = 0; i < 4; i++) l2_txn(1'b1, addr_t'(32 * i), pat(30 + i), cyc, rd);
        write_i = 1'b1;
        addr_i  = 32'h080;
        wdata_i = pat(34);
        idle(3);
        check_eq("t6_draining", line_t'({write_o, addr_o}), line_t'({1'b1, 32'h000}));
        rst = 1'b1;
        write_i = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t6_rst_ctrl", line_t'({resp_o, read_o, write_o}), line_t'(0));
        check_eq("t6_rst_addr", line_t'(addr_o), line_t'(0));
        check_eq("t6_rst_wdata", wdata_o, line_t'(0));
        rst = 1'b0;
        mem_cyc = 0;
        rd_cycles = 0;
        mem_lat = 2;
        l2_txn(1'b0, 32'h000, '0, cyc, rd);
        check_eq("t6_miss_after_rst", line_t'(rd_cycles), line_t'(2));
        check_eq("t6_miss_data", rd, mem_line);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case a DUT event never comes.
    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

endmodule
